// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer:
//   FUNCT field width and the MIPS FUNCT encodings it decodes,
//   plus the sequencer state type.
package muldiv_ctrl_pkg;

    localparam int unsigned FUNCT_W = 6;

    typedef logic [FUNCT_W-1:0] funct_t;

    localparam funct_t FUNCT_MFHI  = 6'h10;
    localparam funct_t FUNCT_MTHI  = 6'h11;
    localparam funct_t FUNCT_MFLO  = 6'h12;
    localparam funct_t FUNCT_MTLO  = 6'h13;
    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1A;
    localparam funct_t FUNCT_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter
//   Iterative restoring divider, one quotient bit per step.
//   load     : capture |dividend|, |divisor| and the result signs
//   step     : perform one shift/compare/subtract step
//   sgn      : operands are two's-complement (sampled on load)
//   quot/rem : sign-corrected quotient and remainder after DATA_WIDTH steps
module div_iter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  sgn,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quot,
    output logic [DATA_WIDTH-1:0] rem
);

    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quot_q;
    logic [DATA_WIDTH-1:0] dvsr_q;
    logic                  qneg_q;
    logic                  rneg_q;

    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH:0]   partial;
    logic [DATA_WIDTH:0]   trial;

    always_comb begin
        a_mag   = (sgn && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
        b_mag   = (sgn && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
        partial = {rem_q, quot_q[DATA_WIDTH-1]};
        // Top bit clear means no borrow, i.e. partial >= divisor.
        trial   = partial - {1'b0, dvsr_q};
        quot    = qneg_q ? -quot_q : quot_q;
        rem     = rneg_q ? -rem_q  : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (load) begin
            rem_q  <= '0;
            quot_q <= a_mag;
            dvsr_q <= b_mag;
            qneg_q <= sgn & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
            rneg_q <= sgn & dividend[DATA_WIDTH-1];
        end else if (step) begin
            if (!trial[DATA_WIDTH]) begin
                rem_q  <= trial[DATA_WIDTH-1:0];
                quot_q <= {quot_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_q  <= partial[DATA_WIDTH-1:0];
                quot_q <= {quot_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Execute-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns HI/LO.
//   clk, rst      : clock, asynchronous active-high reset
//   en            : ID/EX slot valid
//   flush         : cancel any operation in flight (HI/LO untouched)
//   funct         : decoded ALU function
//   op_a, op_b    : rs / rt operands
//   stall_o       : hold PC, IF/ID, ID/EX while the operation runs
//   hi_o, lo_o    : current HI / LO
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    muldiv_state_t state, state_nx;

    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   hi_q, lo_q;
    logic [DATA_WIDTH-1:0]   mul_a, mul_b;
    logic                    mul_sgn;
    logic [2*DATA_WIDTH-1:0] mul_ext_a, mul_ext_b, product;
    logic [DATA_WIDTH-1:0]   div_quot, div_rem;

    logic is_mul, is_div, sgn_op, b_zero, start, mt_ok;
    logic div_load, div_step, mul_commit, div_commit;

    always_comb begin
        is_mul     = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
        is_div     = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
        sgn_op     = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        b_zero     = (op_b == '0);
        start      = en && !flush && (is_mul || is_div) && (state == IDLE);
        mt_ok      = en && !flush && (state == IDLE);
        div_load   = start && is_div && !b_zero;
        div_step   = (state == DIV);
        mul_commit = (state == MUL) && (cnt == '0) && !flush;
        div_commit = (state == FIX) && !flush;

        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = is_mul ? MUL : (b_zero ? DONE : DIV);
            MUL:  if (cnt == '0) state_nx = DONE;
            DIV:  if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;

        // Low in DONE so the held instruction retires there.
        stall_o = !rst && (start || (state == MUL) || (state == DIV) || (state == FIX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_sgn <= 1'b0;
        end else if (start) begin
            cnt <= is_mul ? CNT_W'(MUL_LATENCY - 1) : CNT_W'(DATA_WIDTH - 1);
            if (is_mul) begin
                mul_a   <= op_a;
                mul_b   <= op_b;
                mul_sgn <= sgn_op;
            end
        end else if (((state == MUL) || (state == DIV)) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Sign-extending (or zero-extending) to 2*DATA_WIDTH lets one unsigned
    // multiplier give the correct low 2*DATA_WIDTH bits for both cases.
    always_comb begin
        mul_ext_a = {{DATA_WIDTH{mul_sgn & mul_a[DATA_WIDTH-1]}}, mul_a};
        mul_ext_b = {{DATA_WIDTH{mul_sgn & mul_b[DATA_WIDTH-1]}}, mul_b};
        product   = mul_ext_a * mul_ext_b;
    end

    div_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .sgn      (sgn_op),
        .dividend (op_a),
        .divisor  (op_b),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mul_commit) begin
            hi_q <= product[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_q <= product[DATA_WIDTH-1:0];
        end else if (div_commit) begin
            hi_q <= div_rem;
            lo_q <= div_quot;
        end else if (mt_ok && (funct == FUNCT_MTHI)) begin
            hi_q <= op_a;
        end else if (mt_ok && (funct == FUNCT_MTLO)) begin
            lo_q <= op_a;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
